// File: rtl/i2c_write_reg.sv
// Single-register I2C write sequencer: claims the shared master, issues
// start/write-multiple/stop, then streams the register address and data byte.
module i2c_write_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] dev_address,
    input  logic [7:0] reg_address,
    input  logic [7:0] data,
    input  logic       start,
    output logic       done,
    output logic       message_failure,
    input  logic       timer_exp,
    output logic       timer_start,
    output logic [3:0] timer_param,
    input  logic       i2c_data_in_ready,
    input  logic       i2c_cmd_ready,
    input  logic       i2c_bus_busy,
    input  logic       i2c_bus_control,
    input  logic       i2c_bus_active,
    input  logic       i2c_missed_ack,
    input  logic       i2c_relinquish,
    output logic [7:0] i2c_data_out,
    output logic [5:0] i2c_dev_address,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_write_multiple,
    output logic       i2c_cmd_stop,
    output logic       i2c_cmd_valid,
    output logic       i2c_data_in_valid,
    output logic       i2c_data_in_last,
    output logic       i2c_control,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_BUS  = 4'd1,
        SEND_CMD  = 4'd2,
        SEND_REG  = 4'd3,
        SEND_DATA = 4'd4,
        WAIT_STOP = 4'd5,
        DONE      = 4'd6,
        FAIL      = 4'd7
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] reg_addr_reg, data_reg;
    logic       active, byte_phase, next_active;
    logic       cmd_valid_next, byte_valid_next, last_next, done_next, fail_next;
    logic [7:0] data_out_next;

    always_comb begin
        state_next      = state_reg;
        active          = (state_reg inside {WAIT_BUS, SEND_CMD, SEND_REG, SEND_DATA, WAIT_STOP});
        byte_phase      = (state_reg inside {SEND_REG, SEND_DATA, WAIT_STOP});
        case (state_reg)
            IDLE:      if (start) state_next = WAIT_BUS;
            WAIT_BUS:  if (!i2c_bus_active) state_next = SEND_CMD;
            SEND_CMD:  if (i2c_cmd_ready || i2c_bus_busy) state_next = SEND_REG;
            SEND_REG:  if (i2c_data_in_ready) state_next = SEND_DATA;
            SEND_DATA: if (i2c_data_in_ready) state_next = WAIT_STOP;
            WAIT_STOP: if (!i2c_bus_busy && !i2c_bus_control) state_next = DONE;
            default:   state_next = IDLE;
        endcase
        // Relinquish, timeout and NACK all abort the same way, so their
        // relative priority only matters in that each overrides normal progress.
        if (active && (i2c_relinquish || timer_exp || (byte_phase && i2c_missed_ack)))
            state_next = FAIL;

        // Outputs are decoded from the next state so they change with state_out.
        next_active     = (state_next inside {WAIT_BUS, SEND_CMD, SEND_REG, SEND_DATA, WAIT_STOP});
        cmd_valid_next  = (state_next == SEND_CMD);
        byte_valid_next = (state_next == SEND_REG) || (state_next == SEND_DATA);
        last_next       = (state_next == SEND_DATA);
        done_next       = (state_next == DONE) || (state_next == FAIL);
        fail_next       = (state_next == FAIL);
        data_out_next   = 8'd0;
        if (state_next == SEND_REG)
            data_out_next = reg_addr_reg;
        else if (state_next == SEND_DATA)
            data_out_next = data_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg              <= IDLE;
            reg_addr_reg           <= 8'd0;
            data_reg               <= 8'd0;
            i2c_dev_address        <= 6'd0;
            i2c_control            <= 1'b0;
            timer_start            <= 1'b0;
            timer_param            <= 4'd0;
            i2c_cmd_valid          <= 1'b0;
            i2c_cmd_start          <= 1'b0;
            i2c_cmd_write_multiple <= 1'b0;
            i2c_cmd_stop           <= 1'b0;
            i2c_data_in_valid      <= 1'b0;
            i2c_data_in_last       <= 1'b0;
            i2c_data_out           <= 8'd0;
            done                   <= 1'b0;
            message_failure        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                i2c_dev_address <= dev_address;
                reg_addr_reg    <= reg_address;
                data_reg        <= data;
            end
            i2c_control            <= next_active;
            timer_start            <= next_active && (state_next != state_reg);
            timer_param            <= 4'd3;
            i2c_cmd_valid          <= cmd_valid_next;
            i2c_cmd_start          <= cmd_valid_next;
            i2c_cmd_write_multiple <= cmd_valid_next;
            i2c_cmd_stop           <= cmd_valid_next;
            i2c_data_in_valid      <= byte_valid_next;
            i2c_data_in_last       <= last_next;
            i2c_data_out           <= data_out_next;
            done                   <= done_next;
            message_failure        <= fail_next;
        end
    end

    assign state_out = state_reg;

endmodule

// File: tb/tb_i2c_write_reg.sv
// Randomized bench for i2c_write_reg: each transaction follows an open-loop
// timeline of bus responses with an optional abort, checked against phase arithmetic.
module tb_i2c_write_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, timer_exp, rdy, cmd_ready, busy, bctl, bact, nack, relq;
    logic [5:0] dev_address;
    logic [7:0] reg_address, data;
    logic       done, message_failure, timer_start;
    logic [3:0] timer_param, state_out;
    logic [7:0] i2c_data_out;
    logic [5:0] i2c_dev_address;
    logic       cstart, cwm, cstop, cvalid, dvalid, dlast, ctl;

    i2c_write_reg dut (
        .clk(clk), .reset(reset), .dev_address(dev_address), .reg_address(reg_address),
        .data(data), .start(start), .done(done), .message_failure(message_failure),
        .timer_exp(timer_exp), .timer_start(timer_start), .timer_param(timer_param),
        .i2c_data_in_ready(rdy), .i2c_cmd_ready(cmd_ready), .i2c_bus_busy(busy),
        .i2c_bus_control(bctl), .i2c_bus_active(bact), .i2c_missed_ack(nack),
        .i2c_relinquish(relq), .i2c_data_out(i2c_data_out), .i2c_dev_address(i2c_dev_address),
        .i2c_cmd_start(cstart), .i2c_cmd_write_multiple(cwm), .i2c_cmd_stop(cstop),
        .i2c_cmd_valid(cvalid), .i2c_data_in_valid(dvalid), .i2c_data_in_last(dlast),
        .i2c_control(ctl), .state_out(state_out)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Phase boundaries: the edge index at which each phase's exit condition is sampled.
    int b1, b2, b3, b4, b5, f, kind, mode;

    // kind: 0 none, 1 relinquish, 2 timer_exp, 3 missed_ack, 4 reset; f = abort edge.
    function automatic int exp_state(int c);
        if (kind != 0 && c >= f) return (c == f && kind != 4) ? 7 : 0;
        if (c < 0)  return 0;
        if (c < b1) return 1;
        if (c < b2) return 2;
        if (c < b3) return 3;
        if (c < b4) return 4;
        if (c < b5) return 5;
        if (c == b5) return 6;
        return 0;
    endfunction

    task automatic idle_inputs();
        start = 0; timer_exp = 0; rdy = 0; cmd_ready = 0; busy = 0; bctl = 0;
        bact = 0; nack = 0; relq = 0; dev_address = 0; reg_address = 0; data = 0;
    endtask

    task automatic run_txn(input logic [5:0] dev, input logic [7:0] rg, input logic [7:0] dt,
                           input int t);
        logic [8:0] got[$];
        logic [8:0] expq[$];
        int ign_c, lim, last_c, e;
        int ts, dn, mf, done_at, out_bad, st_bad, dev_bad, tp_bad, exp_ts;
        ts = 0; dn = 0; mf = 0; done_at = -1; out_bad = 0; st_bad = 0; dev_bad = 0; tp_bad = 0;
        lim    = (kind != 0) ? f : b5;
        ign_c  = $urandom_range(1, lim);
        last_c = lim + 3;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == ign_c);
            if (c == 0) begin
                dev_address = dev; reg_address = rg; data = dt;
            end else begin
                dev_address = 6'($urandom); reg_address = 8'($urandom); data = 8'($urandom);
            end
            bact      = (c < b1);
            cmd_ready = (mode == 0) && (c == b2);
            busy      = (mode == 1) ? (c >= b2 && c < b5) : (c > b2 && c < b5);
            bctl      = (c > b2) && (c < b5);
            rdy       = (c == b3) || (c == b4);
            relq      = (kind == 1) && (c == f);
            timer_exp = (kind == 2) && (c == f);
            nack      = (kind == 3) && (c == f);
            reset     = (kind == 4) && (c == f);
            if (c >= 1) begin
                e = exp_state(c - 1);
                if (state_out !== 4'(e)) st_bad++;
                if (ctl !== (e >= 1 && e <= 5)) out_bad++;
                if (cvalid !== (e == 2) || {cstart, cwm, cstop} !== {3{cvalid}}) out_bad++;
                if (dvalid !== (e == 3 || e == 4) || dlast !== (e == 4)) out_bad++;
                if (done !== (e == 6 || e == 7) || message_failure !== (e == 7)) out_bad++;
                if (dvalid && rdy) got.push_back({dlast, i2c_data_out});
                if (timer_start) begin
                    ts++;
                    if (timer_param !== 4'd3) tp_bad++;
                end
                if (done) begin dn++; done_at = c - 1; end
                if (message_failure) mf++;
                if (cvalid && i2c_dev_address !== dev) dev_bad++;
                if (kind == 4 && c - 1 == f)
                    check("reset_all_zero",
                          {done, message_failure, timer_start, timer_param, i2c_data_out,
                           i2c_dev_address, cstart, cwm, cstop, cvalid, dvalid, dlast, ctl,
                           state_out}, 0);
            end
        end
        @(negedge clk);
        idle_inputs();
        reset = 0;

        if (kind == 0 || f >= b3) expq.push_back({1'b0, rg});
        if (kind == 0 || f >= b4) expq.push_back({1'b1, dt});
        exp_ts = 1;
        if (kind == 0 || b1 < f) exp_ts++;
        if (kind == 0 || b2 < f) exp_ts++;
        if (kind == 0 || b3 < f) exp_ts++;
        if (kind == 0 || b4 < f) exp_ts++;

        check("state_trace", st_bad, 0);
        check("strobes", out_bad, 0);
        check("byte_count", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            check("byte", {23'd0, got[i]}, {23'd0, expq[i]});
        check("timer_starts", ts, exp_ts);
        check("timer_param", tp_bad, 0);
        check("done_pulses", dn, (kind == 4) ? 0 : 1);
        check("fail_pulses", mf, (kind >= 1 && kind <= 3) ? 1 : 0);
        if (kind != 4) check("done_cycle", done_at, (kind == 0) ? b5 : f);
        check("dev_address", dev_bad, 0);
        if (t < 6)
            $display("txn %0d kind=%0d mode=%0d b=%0d/%0d/%0d/%0d/%0d f=%0d bytes=%0d done_at=%0d",
                     t, kind, mode, b1, b2, b3, b4, b5, f, got.size(), done_at);
    endtask

    initial begin
        logic [5:0] dev;
        logic [7:0] rg, dt;
        int w1, w2, w3, w4, w5;
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {done, message_failure, timer_start, timer_param, i2c_data_out, i2c_dev_address,
               cstart, cwm, cstop, cvalid, dvalid, dlast, ctl, state_out}, 0);
        reset = 0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {state_out, ctl, done}, 0);

        for (int t = 0; t < 300; t++) begin
            mode = $urandom_range(0, 1);
            w1 = $urandom_range(0, 5); w2 = $urandom_range(0, 3); w3 = $urandom_range(0, 3);
            w4 = $urandom_range(0, 3); w5 = $urandom_range(0, 4);
            dev = 6'($urandom); rg = 8'($urandom); dt = 8'($urandom);
            kind = (t % 3 == 0) ? 0 : $urandom_range(0, 4);
            case (t)
                0: begin dev = 6'h29; rg = 8'h69; dt = 8'h73; w1 = 5; mode = 1; kind = 0; end
                1: begin mode = 0; kind = 0; w2 = 0; end
                2: kind = 3;
                3: begin kind = 2; w1 = $urandom_range(1, 5); end
                4: kind = 1;
                5: begin kind = 4; w5 = $urandom_range(1, 4); end
                default: ;
            endcase
            b1 = 1 + w1; b2 = b1 + 1 + w2; b3 = b2 + 1 + w3; b4 = b3 + 1 + w4; b5 = b4 + 1 + w5;
            case (t)
                2: f = b2 + 1;
                3: f = $urandom_range(1, w1);
                4: f = b3 + 1;
                5: f = b4 + 1;
                default: f = (kind == 3) ? $urandom_range(b2 + 1, b5) : $urandom_range(1, b5);
            endcase
            if (kind == 0) f = 0;
            run_txn(dev, rg, dt, t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
